image_rx_framer: RTL

- Byte-level protocol framer between the UART receiver and the base64 image store.
- Parses the host stream into image_start / data_valid+data_out / chunk_complete / image_end strobes.
- Paces those strobes so the store never drops one during its 13-cycle decode/write burst.
- Returns a one-byte ACK per chunk and per image for host flow control.

---
 rtl/image_link_pkg.sv | 53 +++++
 rtl/rx_strobe_pacer.sv | 98 +++++++++
 rtl/image_rx_framer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/image_link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : image_link_pkg
// Brief    : Shared constants, types and helpers for the host image link
//            (byte codes, framer state, paced strobe event record).
// Revision : 1.0 - initial release
// ============================================================================
package image_link_pkg;

  // Image geometry; 6 bits of pixel data per base64 character
  localparam int IMG_W     = 240;
  localparam int IMG_H     = 128;
  localparam int BPP       = 2;
  localparam int IMG_CHARS = (IMG_W * IMG_H * BPP) / 6;

  // Host protocol bytes
  localparam logic [7:0] BYTE_START = 8'h3C;  // '<'
  localparam logic [7:0] BYTE_END   = 8'h3E;  // '>'
  localparam logic [7:0] BYTE_CHUNK = 8'h0A;  // LF
  localparam logic [7:0] BYTE_CR    = 8'h0D;  // CR, ignored
  localparam logic [7:0] ACK_K      = 8'h4B;  // 'K'
  localparam logic [7:0] ACK_E      = 8'h45;  // 'E'
  localparam logic [7:0] ACK_T      = 8'h54;  // 'T'

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    EV_START = 2'd0,
    EV_DATA  = 2'd1,
    EV_CHUNK = 2'd2,
    EV_END   = 2'd3
  } ev_kind_t;

  // One queued output strobe, optionally carrying the ACK it releases
  typedef struct packed {
    ev_kind_t   kind;
    logic [7:0] data;
    logic       has_ack;
    logic [7:0] ack;
  } strobe_ev_t;

  function automatic logic is_base64(input logic [7:0] b);
    return ((b >= 8'h41) && (b <= 8'h5A)) ||
           ((b >= 8'h61) && (b <= 8'h7A)) ||
           ((b >= 8'h30) && (b <= 8'h39)) ||
           (b == 8'h2B) || (b == 8'h2F) || (b == 8'h3D);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_strobe_pacer.sv
`default_nettype none
// ============================================================================
// Module   : rx_strobe_pacer
// Brief    : Spaces output strobes at least STROBE_GAP cycles apart with a
//            1-deep holding register; reports events lost to overflow.
// Revision : 1.0 - initial release
// ============================================================================
module rx_strobe_pacer
  import image_link_pkg::*;
#(
  parameter int STROBE_GAP = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_valid,
  input  strobe_ev_t ev,
  output logic       data_valid,
  output logic       image_start,
  output logic       image_end,
  output logic       chunk_complete,
  output logic [7:0] data_out,
  output logic       ack_load,
  output logic [7:0] ack_code,
  output logic       overflow
);

  localparam int              GAP_W      = $clog2(STROBE_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(STROBE_GAP - 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             hold_valid;
  strobe_ev_t       hold_ev;
  logic             gap_open;
  logic             fire;
  strobe_ev_t       fire_ev;

  // Choose what fires this cycle: the held event always goes before a new one
  always_comb begin
    gap_open = (gap_cnt == '0);
    fire     = 1'b0;
    fire_ev  = hold_ev;
    if (gap_open && hold_valid) begin
      fire    = 1'b1;
      fire_ev = hold_ev;
    end else if (gap_open && ev_valid) begin
      fire    = 1'b1;
      fire_ev = ev;
    end
    overflow = ev_valid && hold_valid && !gap_open;
    ack_load = fire && fire_ev.has_ack;
    ack_code = fire_ev.ack;
  end

  // Gap counter, holding register and registered strobe outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt        <= '0;
      hold_valid     <= 1'b0;
      hold_ev        <= '0;
      data_valid     <= 1'b0;
      image_start    <= 1'b0;
      image_end      <= 1'b0;
      chunk_complete <= 1'b0;
      data_out       <= 8'h00;
    end else begin
      data_valid     <= 1'b0;
      image_start    <= 1'b0;
      image_end      <= 1'b0;
      chunk_complete <= 1'b0;

      if (fire) begin
        gap_cnt <= GAP_RELOAD;
        case (fire_ev.kind)
          EV_START: image_start    <= 1'b1;
          EV_DATA: begin
            data_valid <= 1'b1;
            data_out   <= fire_ev.data;
          end
          EV_CHUNK: chunk_complete <= 1'b1;
          default:  image_end      <= 1'b1;
        endcase
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end

      // Held event drained this cycle: a new arrival takes its place
      if (gap_open && hold_valid) begin
        hold_valid <= ev_valid;
        if (ev_valid) hold_ev <= ev;
      end else if (!gap_open && ev_valid && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_ev    <= ev;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/image_rx_framer.sv
`default_nettype none
// ============================================================================
// Module   : image_rx_framer
// Brief    : Parses the host byte stream into paced image/chunk/data strobes
//            for the base64 image store and returns per-chunk/image ACKs.
// Revision : 1.0 - initial release
// ============================================================================
module image_rx_framer
  import image_link_pkg::*;
#(
  parameter int EXPECTED_CHARS = IMG_CHARS,
  parameter int STROBE_GAP     = 16,
  parameter int TIMEOUT_CYCLES = 27000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        image_start,
  output logic        image_end,
  output logic        chunk_complete,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        image_error,
  output logic [15:0] char_count,
  output logic        busy
);

  localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  // The strobe is registered, so triggering here lands image_end exactly
  // TIMEOUT_CYCLES cycles after the cycle of the last received byte.
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [15:0]      EXP16   = 16'(EXPECTED_CHARS);

  state_t          state;
  state_t          state_next;
  logic [1:0]      quartet;
  logic            chunk_err;
  logic [TO_W-1:0] idle_cnt;

  logic            ev_valid;
  strobe_ev_t      ev;
  logic            start_img;
  logic            data_acc;
  logic            chunk_end;
  logic            bad_byte;
  logic            set_err;
  logic            end_ok;
  logic            pacer_overflow;
  logic            ack_load;
  logic [7:0]      ack_code;

  assign busy   = (state == PAYLOAD);
  assign end_ok = (char_count == EXP16) && (quartet == 2'd0) && !image_error;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Byte classification, next state and event to queue
  always_comb begin
    state_next = state;
    ev_valid   = 1'b0;
    ev         = '{kind: EV_START, data: 8'h00, has_ack: 1'b0, ack: 8'h00};
    start_img  = 1'b0;
    data_acc   = 1'b0;
    chunk_end  = 1'b0;
    bad_byte   = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && (rx_data == BYTE_START)) begin
          ev_valid   = 1'b1;
          start_img  = 1'b1;
          state_next = PAYLOAD;
        end
      end
      default: begin
        if (rx_valid) begin
          if (is_base64(rx_data)) begin
            ev_valid = 1'b1;
            ev.kind  = EV_DATA;
            ev.data  = rx_data;
            data_acc = 1'b1;
          end else if (rx_data == BYTE_CR) begin
            ev_valid = 1'b0;
          end else if (rx_data == BYTE_CHUNK) begin
            ev_valid   = 1'b1;
            ev.kind    = EV_CHUNK;
            ev.has_ack = 1'b1;
            ev.ack     = ((quartet == 2'd0) && !chunk_err) ? ACK_K : ACK_E;
            chunk_end  = 1'b1;
          end else if (rx_data == BYTE_END) begin
            ev_valid   = 1'b1;
            ev.kind    = EV_END;
            ev.has_ack = 1'b1;
            ev.ack     = end_ok ? ACK_K : ACK_E;
            set_err    = !end_ok;
            state_next = IDLE;
          end else begin
            bad_byte = 1'b1;
            set_err  = 1'b1;
          end
        end else if (idle_cnt == TO_LAST) begin
          ev_valid   = 1'b1;
          ev.kind    = EV_END;
          ev.has_ack = 1'b1;
          ev.ack     = ACK_T;
          set_err    = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // Per-image bookkeeping: char count, quartet alignment, error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      char_count  <= 16'h0000;
      quartet     <= 2'd0;
      chunk_err   <= 1'b0;
      image_error <= 1'b0;
    end else begin
      if (start_img) begin
        char_count  <= 16'h0000;
        quartet     <= 2'd0;
        chunk_err   <= 1'b0;
        image_error <= 1'b0;
      end else begin
        if (data_acc) begin
          if (char_count != 16'hFFFF) char_count <= char_count + 16'd1;
          quartet <= quartet + 2'd1;
        end
        if (chunk_end) begin
          quartet   <= 2'd0;
          chunk_err <= 1'b0;
        end
        if (bad_byte) chunk_err <= 1'b1;
      end
      // A dropped START event still flags the image it belongs to
      if (set_err || pacer_overflow) image_error <= 1'b1;
    end
  end

  // Inactivity counter inside an image
  always_ff @(posedge clk) begin
    if (reset || (state != PAYLOAD) || rx_valid) idle_cnt <= '0;
    else                                         idle_cnt <= idle_cnt + 1'b1;
  end

  // ACK register: loaded when its strobe fires, merged if still pending
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (ack_load) begin
        tx_valid <= 1'b1;
        if (tx_valid && !tx_ready)
          tx_data <= ((tx_data == ACK_K) && (ack_code == ACK_K)) ? ACK_K : ACK_E;
        else
          tx_data <= ack_code;
      end
    end
  end

  rx_strobe_pacer #(
    .STROBE_GAP (STROBE_GAP)
  ) u_pacer (
    .clk            (clk),
    .reset          (reset),
    .ev_valid       (ev_valid),
    .ev             (ev),
    .data_valid     (data_valid),
    .image_start    (image_start),
    .image_end      (image_end),
    .chunk_complete (chunk_complete),
    .data_out       (data_out),
    .ack_load       (ack_load),
    .ack_code       (ack_code),
    .overflow       (pacer_overflow)
  );

endmodule
`default_nettype wire
